rob_ctrl: RTL and testbench

Sequencing controller for the 16-entry re-order buffer. It allocates ROB indices to the two instructions dispatched each cycle and records completions reported by the three functional units. It selects up to two in-order retirements per cycle and signals end of program. It sits between dispatch, the FU result buses and the complete/retire datapath. It owns the head/tail pointers, occupancy and valid/complete bits; the datapath holds entry payloads.

---
 rtl/rob_ctrl_pkg.sv | 11 +
 rtl/rob_ctrl_if.sv | 52 +++++
 rtl/rob_ctrl.sv | 134 +++++++++++++
 tb/tb_rob_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rob_ctrl_pkg.sv
// Shared ROB sizing constants and index/occupancy types.
package rob_ctrl_pkg;

    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned ROB_IDX_W = 4;
    localparam int unsigned INSTR_W   = 32;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [ROB_IDX_W:0]   rob_cnt_t;

endpackage

// File: rtl/rob_ctrl_if.sv
// Dispatch, completion, retire and status signals of the ROB controller.
interface rob_ctrl_if;
    import rob_ctrl_pkg::*;

    logic                 disp_valid_1;
    logic                 disp_valid_2;
    logic                 disp_ready;
    rob_idx_t             disp_idx_1;
    rob_idx_t             disp_idx_2;

    logic                 cmp_valid_1;
    logic                 cmp_valid_2;
    logic                 cmp_valid_3;
    rob_idx_t             cmp_rob_1;
    rob_idx_t             cmp_rob_2;
    rob_idx_t             cmp_rob_3;

    logic                 rt_valid_1;
    logic                 rt_valid_2;
    rob_idx_t             rt_idx_1;
    rob_idx_t             rt_idx_2;

    rob_cnt_t             count;
    logic                 full;
    logic                 empty;
    logic [INSTR_W-1:0]   tot_instr_count;
    logic [INSTR_W-1:0]   instr_retired;
    logic                 done;

    // Dispatch/FU side driving the controller.
    modport master (
        output disp_valid_1, disp_valid_2,
        output cmp_valid_1, cmp_valid_2, cmp_valid_3,
        output cmp_rob_1, cmp_rob_2, cmp_rob_3,
        output tot_instr_count,
        input  disp_ready, disp_idx_1, disp_idx_2,
        input  rt_valid_1, rt_valid_2, rt_idx_1, rt_idx_2,
        input  count, full, empty, instr_retired, done
    );

    // The controller itself.
    modport slave (
        input  disp_valid_1, disp_valid_2,
        input  cmp_valid_1, cmp_valid_2, cmp_valid_3,
        input  cmp_rob_1, cmp_rob_2, cmp_rob_3,
        input  tot_instr_count,
        output disp_ready, disp_idx_1, disp_idx_2,
        output rt_valid_1, rt_valid_2, rt_idx_1, rt_idx_2,
        output count, full, empty, instr_retired, done
    );

endinterface

// File: rtl/rob_ctrl.sv
// ROB sequencing controller: allocates indices, records completions and
// retires up to two entries per cycle in order.
module rob_ctrl
    import rob_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    rob_ctrl_if.slave  bus
);

    rob_idx_t               r_head;
    rob_idx_t               r_tail;
    rob_cnt_t               r_count;
    logic [ROB_DEPTH-1:0]   r_v;
    logic [ROB_DEPTH-1:0]   r_c;
    logic                   r_rt_valid_1;
    logic                   r_rt_valid_2;
    rob_idx_t               r_rt_idx_1;
    rob_idx_t               r_rt_idx_2;
    logic [INSTR_W-1:0]     r_instr_retired;
    logic                   r_done;

    logic                   w_disp_ready;
    rob_idx_t               w_tail_p1;
    rob_idx_t               w_head_p1;
    logic                   w_alloc_1;
    logic                   w_alloc_2;
    logic                   w_ret_1;
    logic                   w_ret_2;
    logic [1:0]             w_n_alloc;
    logic [1:0]             w_n_ret;
    rob_idx_t               w_head_next;
    rob_idx_t               w_tail_next;
    rob_cnt_t               w_count_next;
    logic [ROB_DEPTH-1:0]   w_v_next;
    logic [ROB_DEPTH-1:0]   w_c_next;
    rob_idx_t               w_rt_idx_1_next;
    rob_idx_t               w_rt_idx_2_next;
    logic [INSTR_W-1:0]     w_instr_next;
    logic                   w_done_next;

    // Next-state: completions mark pre-edge valid entries, retire clears head
    // slots, allocation claims tail slots (never the same slots as retire).
    always_comb begin
        w_disp_ready    = (r_count <= rob_cnt_t'(ROB_DEPTH - 2)) && !r_done;
        w_tail_p1       = r_tail + rob_idx_t'(1);
        w_head_p1       = r_head + rob_idx_t'(1);
        w_alloc_1       = bus.disp_valid_1 && w_disp_ready;
        w_alloc_2       = w_alloc_1 && bus.disp_valid_2;
        w_ret_1         = r_v[r_head] && r_c[r_head];
        w_ret_2         = w_ret_1 && r_v[w_head_p1] && r_c[w_head_p1];
        w_n_alloc       = 2'(w_alloc_1) + 2'(w_alloc_2);
        w_n_ret         = 2'(w_ret_1) + 2'(w_ret_2);
        w_v_next        = r_v;
        w_c_next        = r_c;
        w_rt_idx_1_next = r_rt_idx_1;
        w_rt_idx_2_next = r_rt_idx_2;

        if (bus.cmp_valid_1 && r_v[bus.cmp_rob_1]) w_c_next[bus.cmp_rob_1] = 1'b1;
        if (bus.cmp_valid_2 && r_v[bus.cmp_rob_2]) w_c_next[bus.cmp_rob_2] = 1'b1;
        if (bus.cmp_valid_3 && r_v[bus.cmp_rob_3]) w_c_next[bus.cmp_rob_3] = 1'b1;

        if (w_ret_1) begin
            w_v_next[r_head] = 1'b0;
            w_c_next[r_head] = 1'b0;
            w_rt_idx_1_next  = r_head;
        end
        if (w_ret_2) begin
            w_v_next[w_head_p1] = 1'b0;
            w_c_next[w_head_p1] = 1'b0;
            w_rt_idx_2_next     = w_head_p1;
        end

        if (w_alloc_1) begin
            w_v_next[r_tail] = 1'b1;
            w_c_next[r_tail] = 1'b0;
        end
        if (w_alloc_2) begin
            w_v_next[w_tail_p1] = 1'b1;
            w_c_next[w_tail_p1] = 1'b0;
        end

        w_head_next  = r_head + rob_idx_t'(w_n_ret);
        w_tail_next  = r_tail + rob_idx_t'(w_n_alloc);
        w_count_next = r_count + rob_cnt_t'(w_n_alloc) - rob_cnt_t'(w_n_ret);
        w_instr_next = r_instr_retired + INSTR_W'(w_n_ret);
        w_done_next  = r_done ||
                       ((bus.tot_instr_count != '0) &&
                        (w_instr_next >= bus.tot_instr_count));
    end

    // Registered state update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_v             <= '0;
            r_c             <= '0;
            r_rt_valid_1    <= 1'b0;
            r_rt_valid_2    <= 1'b0;
            r_rt_idx_1      <= '0;
            r_rt_idx_2      <= '0;
            r_instr_retired <= '0;
            r_done          <= 1'b0;
        end else begin
            r_head          <= w_head_next;
            r_tail          <= w_tail_next;
            r_count         <= w_count_next;
            r_v             <= w_v_next;
            r_c             <= w_c_next;
            r_rt_valid_1    <= w_ret_1;
            r_rt_valid_2    <= w_ret_2;
            r_rt_idx_1      <= w_rt_idx_1_next;
            r_rt_idx_2      <= w_rt_idx_2_next;
            r_instr_retired <= w_instr_next;
            r_done          <= w_done_next;
        end
    end

    assign bus.disp_ready    = w_disp_ready;
    assign bus.disp_idx_1    = r_tail;
    assign bus.disp_idx_2    = w_tail_p1;
    assign bus.rt_valid_1    = r_rt_valid_1;
    assign bus.rt_valid_2    = r_rt_valid_2;
    assign bus.rt_idx_1      = r_rt_idx_1;
    assign bus.rt_idx_2      = r_rt_idx_2;
    assign bus.count         = r_count;
    assign bus.full          = (r_count == rob_cnt_t'(ROB_DEPTH));
    assign bus.empty         = (r_count == '0);
    assign bus.instr_retired = r_instr_retired;
    assign bus.done          = r_done;

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl with hand-computed expectations.
module tb_rob_ctrl;
    import rob_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rob_ctrl_if bus();

    rob_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid_1 = 1'b0;
        bus.disp_valid_2 = 1'b0;
        bus.cmp_valid_1  = 1'b0;
        bus.cmp_valid_2  = 1'b0;
        bus.cmp_valid_3  = 1'b0;
        bus.cmp_rob_1    = '0;
        bus.cmp_rob_2    = '0;
        bus.cmp_rob_3    = '0;
    endtask

    task automatic disp(input logic v1, input logic v2);
        idle();
        bus.disp_valid_1 = v1;
        bus.disp_valid_2 = v2;
        tick();
        idle();
    endtask

    task automatic cmp(input logic v1, input rob_idx_t r1,
                       input logic v2, input rob_idx_t r2,
                       input logic v3, input rob_idx_t r3);
        idle();
        bus.cmp_valid_1 = v1; bus.cmp_rob_1 = r1;
        bus.cmp_valid_2 = v2; bus.cmp_rob_2 = r2;
        bus.cmp_valid_3 = v3; bus.cmp_rob_3 = r3;
        tick();
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.tot_instr_count = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_count", 32'(bus.count), 0);
        check_eq("rst_empty", 32'(bus.empty), 1);
        check_eq("rst_full", 32'(bus.full), 0);
        check_eq("rst_ready", 32'(bus.disp_ready), 1);
        check_eq("rst_idx1", 32'(bus.disp_idx_1), 0);
        check_eq("rst_idx2", 32'(bus.disp_idx_2), 1);
        check_eq("rst_rtv1", 32'(bus.rt_valid_1), 0);
        check_eq("rst_done", 32'(bus.done), 0);

        // Pair 0/1, complete 1 then 0, both retire together
        disp(1'b1, 1'b1);
        check_eq("p1_count", 32'(bus.count), 2);
        check_eq("p1_idx1", 32'(bus.disp_idx_1), 2);
        cmp(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 4'd0);
        check_eq("hd_incomplete_rtv1", 32'(bus.rt_valid_1), 0);
        check_eq("hd_incomplete_rtv2", 32'(bus.rt_valid_2), 0);
        cmp(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        check_eq("no_bypass_rtv1", 32'(bus.rt_valid_1), 0);
        tick();
        check_eq("r01_rtv1", 32'(bus.rt_valid_1), 1);
        check_eq("r01_rtv2", 32'(bus.rt_valid_2), 1);
        check_eq("r01_idx1", 32'(bus.rt_idx_1), 0);
        check_eq("r01_idx2", 32'(bus.rt_idx_2), 1);
        check_eq("r01_count", 32'(bus.count), 0);
        check_eq("r01_instr", bus.instr_retired, 2);
        tick();
        check_eq("empty_rtv1", 32'(bus.rt_valid_1), 0);
        check_eq("empty_idx1_hold", 32'(bus.rt_idx_1), 0);

        // Entries 2/3: triple completion on 3, invalid index 9, then 2
        disp(1'b1, 1'b1);
        cmp(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3);
        check_eq("dup_rtv1", 32'(bus.rt_valid_1), 0);
        check_eq("dup_count", 32'(bus.count), 2);
        cmp(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0);
        check_eq("inv_rtv1", 32'(bus.rt_valid_1), 0);
        cmp(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        check_eq("hd_edge_rtv1", 32'(bus.rt_valid_1), 0);
        tick();
        check_eq("r23_idx1", 32'(bus.rt_idx_1), 2);
        check_eq("r23_idx2", 32'(bus.rt_idx_2), 3);
        check_eq("r23_rtv2", 32'(bus.rt_valid_2), 1);
        check_eq("r23_count", 32'(bus.count), 0);
        check_eq("r23_instr", bus.instr_retired, 4);

        // Fill with 8 pairs from tail 4
        for (int i = 0; i < 8; i++) disp(1'b1, 1'b1);
        check_eq("fill_count", 32'(bus.count), 16);
        check_eq("fill_full", 32'(bus.full), 1);
        check_eq("fill_ready", 32'(bus.disp_ready), 0);
        disp(1'b1, 1'b1);
        check_eq("drop_count", 32'(bus.count), 16);
        check_eq("drop_idx1", 32'(bus.disp_idx_1), 4);

        // Drain two per cycle, crossing 15->0
        for (int j = 0; j <= 8; j++) begin
            idle();
            if (j < 8) begin
                bus.cmp_valid_1 = 1'b1; bus.cmp_rob_1 = rob_idx_t'(4 + 2 * j);
                bus.cmp_valid_2 = 1'b1; bus.cmp_rob_2 = rob_idx_t'(5 + 2 * j);
            end
            tick();
            if (j == 0) begin
                check_eq("drain_first_rtv1", 32'(bus.rt_valid_1), 0);
            end else begin
                check_eq("drain_rtv1", 32'(bus.rt_valid_1), 1);
                check_eq("drain_rtv2", 32'(bus.rt_valid_2), 1);
                check_eq("drain_idx1", 32'(bus.rt_idx_1), 32'((4 + 2 * (j - 1)) % 16));
                check_eq("drain_idx2", 32'(bus.rt_idx_2), 32'((5 + 2 * (j - 1)) % 16));
            end
        end
        idle();
        check_eq("drain_count", 32'(bus.count), 0);
        check_eq("drain_instr", bus.instr_retired, 20);

        // Tail wrap: 5 pairs + single from 4 leaves tail at 15
        for (int i = 0; i < 5; i++) disp(1'b1, 1'b1);
        disp(1'b1, 1'b0);
        check_eq("wrap_count", 32'(bus.count), 11);
        check_eq("wrap_idx1", 32'(bus.disp_idx_1), 15);
        check_eq("wrap_idx2", 32'(bus.disp_idx_2), 0);
        disp(1'b1, 1'b1);
        check_eq("wrap_after_idx1", 32'(bus.disp_idx_1), 1);
        disp(1'b1, 1'b1);
        check_eq("c15_count", 32'(bus.count), 15);
        check_eq("c15_ready", 32'(bus.disp_ready), 0);
        check_eq("c15_full", 32'(bus.full), 0);

        // Mid-run reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_count", 32'(bus.count), 0);
        check_eq("mrst_idx1", 32'(bus.disp_idx_1), 0);
        check_eq("mrst_instr", bus.instr_retired, 0);
        check_eq("mrst_ready", 32'(bus.disp_ready), 1);

        // End of program after 4 retirements
        bus.tot_instr_count = 32'd4;
        disp(1'b1, 1'b1);
        disp(1'b1, 1'b1);
        check_eq("eop_count", 32'(bus.count), 4);
        cmp(1'b1, 4'd0, 1'b1, 4'd1, 1'b1, 4'd2);
        cmp(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
        check_eq("eop_instr2", bus.instr_retired, 2);
        check_eq("eop_done_early", 32'(bus.done), 0);
        tick();
        check_eq("eop_instr4", bus.instr_retired, 4);
        check_eq("eop_done", 32'(bus.done), 1);
        check_eq("eop_ready", 32'(bus.disp_ready), 0);
        disp(1'b1, 1'b1);
        check_eq("eop_done_sticky", 32'(bus.done), 1);
        check_eq("eop_no_alloc", 32'(bus.count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
